// File: rtl/bnn_layer_engine.sv
// Binary fully-connected layer engine: XNOR-popcount over LANES-bit beats,
// one neuron at a time, with a sign-bit write-back or a raw-sum stream.
module bnn_layer_engine #(
    parameter int LANES      = 8,
    parameter int W_ADDR_LEN = 20,
    parameter int X_ADDR_LEN = 10,
    parameter int SEL_LEN    = 2,
    parameter int CNT_LEN    = 11,
    parameter int ACC_W      = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_LEN-1:0]      n_in,
    input  logic [CNT_LEN-1:0]      n_out,
    input  logic                    mode,
    input  logic [W_ADDR_LEN-1:0]   w_base,
    input  logic [SEL_LEN-1:0]      w_bank,
    input  logic [SEL_LEN-1:0]      rd_bank,
    input  logic [SEL_LEN-1:0]      wr_bank,
    output logic                    busy,
    output logic                    done,
    output logic [W_ADDR_LEN-1:0]   w_addr,
    output logic [SEL_LEN-1:0]      w_sel,
    input  logic [LANES-1:0]        w_data,
    output logic [X_ADDR_LEN-1:0]   x_addr,
    output logic [SEL_LEN-1:0]      x_sel,
    input  logic [LANES-1:0]        x_data,
    output logic                    x_we,
    output logic                    x_wdata,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    acc_valid
);
    localparam int VW = $clog2(LANES + 1);
    localparam int KW = CNT_LEN + 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_EMIT, S_DONE} state_e;

    state_e                    state_q;
    logic [CNT_LEN-1:0]        n_in_q, n_out_q, j_q;
    logic [KW-1:0]             k_q;
    logic                      mode_q;
    logic [SEL_LEN-1:0]        rd_bank_q, wr_bank_q, w_sel_q, x_sel_q;
    logic [W_ADDR_LEN-1:0]     w_addr_q;
    logic [X_ADDR_LEN-1:0]     x_addr_q;
    logic                      busy_q, done_q, x_we_q, x_wdata_q, acc_valid_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_out_q;
    logic [RD_LAT-1:0]         vld_q;
    logic [RD_LAT-1:0][VW-1:0] vcnt_q;

    logic [KW-1:0]    words;
    logic [31:0]      rem_w;
    logic [VW-1:0]    last_v, issue_v, m_w;
    logic             is_last, issue, pipe_busy;
    logic [LANES-1:0] match_w;

    assign words   = KW'((32'(n_in_q) + 32'(LANES) - 32'd1) / 32'(LANES));
    assign rem_w   = 32'(n_in_q) % 32'(LANES);
    assign last_v  = (rem_w == 32'd0) ? VW'(LANES) : VW'(rem_w);
    assign is_last = (k_q == words - KW'(1));
    assign issue_v = is_last ? last_v : VW'(LANES);
    assign issue   = (state_q == S_ISSUE);
    assign match_w = ~(w_data ^ x_data);

    // Beats still in flight other than the one returning this cycle.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) pipe_busy = pipe_busy | vld_q[i];
    end

    // Each valid lane adds +1 on match, -1 otherwise: 2*m - v.
    always_comb begin
        m_w = '0;
        for (int i = 0; i < LANES; i++)
            if (i < int'(vcnt_q[RD_LAT-1]) && match_w[i]) m_w = m_w + VW'(1);
        acc_d = acc_q;
        if (vld_q[RD_LAT-1])
            acc_d = acc_q + ACC_W'({m_w, 1'b0}) - ACC_W'(vcnt_q[RD_LAT-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            vcnt_q <= '0;
        end else begin
            vld_q[0]  <= issue;
            vcnt_q[0] <= issue_v;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                vcnt_q[i] <= vcnt_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_in_q      <= '0;
            n_out_q     <= '0;
            j_q         <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            rd_bank_q   <= '0;
            wr_bank_q   <= '0;
            w_sel_q     <= '0;
            x_sel_q     <= '0;
            w_addr_q    <= '0;
            x_addr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            x_we_q      <= 1'b0;
            x_wdata_q   <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_q       <= '0;
            acc_out_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            x_we_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_q       <= acc_d;
            case (state_q)
                S_IDLE: if (start) begin
                    n_in_q    <= n_in;
                    n_out_q   <= n_out;
                    mode_q    <= mode;
                    rd_bank_q <= rd_bank;
                    wr_bank_q <= wr_bank;
                    if (n_in == '0 || n_out == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_ISSUE;
                        busy_q   <= 1'b1;
                        w_addr_q <= w_base;
                        w_sel_q  <= w_bank;
                        x_addr_q <= '0;
                        x_sel_q  <= rd_bank;
                        j_q      <= '0;
                        k_q      <= '0;
                        acc_q    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (is_last) begin
                        state_q <= S_DRAIN;
                    end else begin
                        k_q      <= k_q + KW'(1);
                        w_addr_q <= w_addr_q + W_ADDR_LEN'(1);
                        x_addr_q <= X_ADDR_LEN'(k_q + KW'(1));
                    end
                end
                S_DRAIN: if (!pipe_busy) begin
                    // acc_d already includes the final beat returning this cycle.
                    state_q <= S_EMIT;
                    if (!mode_q) begin
                        x_we_q    <= 1'b1;
                        x_sel_q   <= wr_bank_q;
                        x_addr_q  <= X_ADDR_LEN'(j_q);
                        x_wdata_q <= ~acc_d[ACC_W-1];
                    end else begin
                        acc_out_q   <= acc_d;
                        acc_valid_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    acc_q <= '0;
                    if (j_q + CNT_LEN'(1) == n_out_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_ISSUE;
                        j_q      <= j_q + CNT_LEN'(1);
                        k_q      <= '0;
                        w_addr_q <= w_addr_q + W_ADDR_LEN'(1);
                        x_addr_q <= '0;
                        x_sel_q  <= rd_bank_q;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign w_addr    = w_addr_q;
    assign w_sel     = w_sel_q;
    assign x_addr    = x_addr_q;
    assign x_sel     = x_sel_q;
    assign x_we      = x_we_q;
    assign x_wdata   = x_wdata_q;
    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
endmodule

// File: tb/tb_bnn_layer_engine.sv
// Randomised bench for bnn_layer_engine: latency-modelled memories and a
// per-input-bit reference sum for every neuron.
module tb_bnn_layer_engine;
    localparam int LANES = 8, RD_LAT = 3, WA = 20, XA = 10, SL = 2, CL = 11, AW = 12;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic [CL-1:0] n_in = '0, n_out = '0;
    logic [WA-1:0] w_base = '0;
    logic [SL-1:0] w_bank = '0, rd_bank = '0, wr_bank = '0;
    logic busy, done, x_we, x_wdata, acc_valid;
    logic [WA-1:0] w_addr;
    logic [SL-1:0] w_sel, x_sel;
    logic [XA-1:0] x_addr;
    logic [LANES-1:0] w_data, x_data;
    logic signed [AW-1:0] acc_out;

    bnn_layer_engine #(.LANES(LANES), .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .SEL_LEN(SL),
                       .CNT_LEN(CL), .ACC_W(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .n_out(n_out), .mode(mode),
        .w_base(w_base), .w_bank(w_bank), .rd_bank(rd_bank), .wr_bank(wr_bank),
        .busy(busy), .done(done), .w_addr(w_addr), .w_sel(w_sel), .w_data(w_data),
        .x_addr(x_addr), .x_sel(x_sel), .x_data(x_data), .x_we(x_we), .x_wdata(x_wdata),
        .acc_out(acc_out), .acc_valid(acc_valid));

    always #5 clk = ~clk;

    logic [7:0] wmem [4][4096];
    logic [7:0] xmem [4][1024];
    logic [7:0] wp [RD_LAT];
    logic [7:0] xp [RD_LAT];

    always @(posedge clk) begin
        wp[0] <= wmem[w_sel][w_addr[11:0]];
        xp[0] <= xmem[x_sel][x_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            wp[i] <= wp[i-1];
            xp[i] <= xp[i-1];
        end
    end
    assign w_data = wp[RD_LAT-1];
    assign x_data = xp[RD_LAT-1];

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sum over input bits i of (+1 if w_i == x_i else -1).
    function automatic int ref_acc(int ni, int base, int wb, int rb, int j);
        int words = (ni + 7) / 8;
        int s = 0;
        logic [7:0] wv, xv;
        for (int i = 0; i < ni; i++) begin
            wv = wmem[wb][(base + j * words + i / 8) % 4096];
            xv = xmem[rb][i / 8];
            s += (wv[i % 8] == xv[i % 8]) ? 1 : -1;
        end
        return s;
    endfunction

    task automatic run_layer(input string nm, input int ni, input int no, input bit md,
                             input int base, input int wb, input int rb, input int wrb,
                             input bit poke);
        int exp_acc[$], we_a[$], we_d[$], av[$];
        int words, busy_cnt, done_cyc, exp_done, cyc;
        words = (ni + 7) / 8;
        for (int j = 0; j < no; j++) exp_acc.push_back(ref_acc(ni, base, wb, rb, j));
        @(negedge clk);
        n_in = CL'(ni); n_out = CL'(no); mode = md; w_base = WA'(base);
        w_bank = SL'(wb); rd_bank = SL'(rb); wr_bank = SL'(wrb); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (ni != 0 && no != 0) begin
            chk({nm, ".w_addr0"}, int'(w_addr), base);
            chk({nm, ".w_sel"}, int'(w_sel), wb);
            chk({nm, ".x_sel_rd"}, int'(x_sel), rb);
            chk({nm, ".x_addr0"}, int'(x_addr), 0);
        end
        cyc = 1; busy_cnt = 0; done_cyc = -1;
        while (cyc < 2000) begin
            if (busy) busy_cnt++;
            if (x_we) begin
                we_a.push_back(int'(x_addr));
                we_d.push_back(int'(x_wdata));
                chk({nm, ".we_sel"}, int'(x_sel), wrb);
                xmem[x_sel][x_addr[9:3]][x_addr[2:0]] = x_wdata;
            end
            if (acc_valid) av.push_back(int'(acc_out));
            if (done) begin
                done_cyc = cyc;
                chk({nm, ".busy_at_done"}, int'(busy), 0);
                break;
            end
            if (poke && cyc == 4) begin
                start = 1'b1; n_in = '0; n_out = 5; mode = ~md;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        exp_done = (ni == 0 || no == 0) ? 1 : no * (words + RD_LAT + 1) + 1;
        chk({nm, ".done_cyc"}, done_cyc, exp_done);
        chk({nm, ".busy_cyc"}, busy_cnt, exp_done - 1);
        chk({nm, ".we_cnt"}, we_a.size(), (md || ni == 0) ? 0 : no);
        chk({nm, ".av_cnt"}, av.size(), (!md || ni == 0) ? 0 : no);
        for (int j = 0; j < we_a.size() && j < no; j++) begin
            chk({nm, ".we_addr"}, we_a[j], j);
            chk({nm, ".we_bit"}, we_d[j], (exp_acc[j] >= 0) ? 1 : 0);
        end
        for (int j = 0; j < av.size() && j < no; j++) chk({nm, ".acc"}, av[j], exp_acc[j]);
        @(negedge clk);
        chk({nm, ".done_pulse"}, int'(done), 0);
        if (md && ni != 0 && no != 0) chk({nm, ".acc_hold"}, int'(acc_out), exp_acc[no-1]);
    endtask

    initial begin
        int rb;
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 4096; a++) wmem[b][a] = 8'($urandom);
            for (int a = 0; a < 1024; a++) xmem[b][a] = 8'($urandom);
        end
        repeat (2) @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.x_we", int'(x_we), 0);
        chk("rst.acc_valid", int'(acc_valid), 0);
        chk("rst.w_addr", int'(w_addr), 0);
        chk("rst.acc_out", int'(acc_out), 0);
        rst_n = 1'b1;

        wmem[0][0] = 8'hFF; xmem[1][0] = 8'hFF;
        run_layer("all_match", 8, 1, 1'b0, 0, 0, 1, 2, 1'b0);

        wmem[0][10] = 8'h00; wmem[0][11] = {6'($urandom), 2'b00};
        xmem[1][0] = 8'hFF;  xmem[1][1] = {6'($urandom), 2'b11};
        run_layer("two_word", 10, 1, 1'b0, 10, 0, 1, 2, 1'b0);

        wmem[3][20] = {4'($urandom), 4'b0011}; xmem[2][0] = {4'($urandom), 4'b0101};
        run_layer("tie_m0", 4, 1, 1'b0, 20, 3, 2, 0, 1'b0);
        run_layer("tie_m1", 4, 1, 1'b1, 20, 3, 2, 0, 1'b0);

        run_layer("three_poke", 16, 3, 1'b0, 30, 1, 0, 3, 1'b1);
        run_layer("n_in0", 0, 2, 1'b0, 0, 0, 1, 2, 1'b0);
        run_layer("n_out0", 5, 0, 1'b1, 0, 0, 1, 2, 1'b0);

        for (int t = 0; t < 8; t++) begin
            rb = int'($urandom_range(0, 3));
            run_layer($sformatf("rnd%0d", t), int'($urandom_range(1, 40)),
                      int'($urandom_range(1, 6)), 1'($urandom), int'($urandom_range(100, 2000)),
                      int'($urandom_range(0, 3)), rb, (rb + 1) % 4, 1'b0);
        end

        @(negedge clk);
        n_in = 24; n_out = 2; mode = 1'b0; w_base = 50; w_bank = 0; rd_bank = 1; wr_bank = 2;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.w_addr", int'(w_addr), 0);
        chk("midrst.x_addr", int'(x_addr), 0);
        chk("midrst.w_sel", int'(w_sel), 0);
        chk("midrst.x_we", int'(x_we), 0);
        chk("midrst.acc_out", int'(acc_out), 0);
        @(negedge clk); rst_n = 1'b1;
        run_layer("after_rst", 24, 2, 1'b1, 50, 0, 1, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
